// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage: owns the PC, issues imem reads and fills the IF/ID boundary.
// Handles decode stalls with a one-word skid buffer and redirects with flush.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic        valid
);

  localparam int unsigned XLEN = 16;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(2);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] pc, pc_d;
  logic [XLEN-1:0] buf_instr, buf_instr_d;
  logic [XLEN-1:0] buf_pc, buf_pc_d;
  logic [XLEN-1:0] tgt, tgt_d;
  logic [XLEN-1:0] instruction_d, pc_out_d, pc_plus2_d;
  logic            valid_d;
  logic [XLEN-1:0] redirect_tgt_c;

  assign redirect_tgt_c = {redirect_pc[XLEN-1:1], 1'b0};

  // Memory request is decoded from state so the address is stable until resp.
  assign imem_read    = !reset && (state == FETCH || state == DISCARD);
  assign imem_address = pc;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= {RESET_PC[XLEN-1:1], 1'b0};
      buf_instr   <= '0;
      buf_pc      <= '0;
      tgt         <= '0;
      instruction <= '0;
      pc_out      <= '0;
      pc_plus2    <= '0;
      valid       <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      buf_instr   <= buf_instr_d;
      buf_pc      <= buf_pc_d;
      tgt         <= tgt_d;
      instruction <= instruction_d;
      pc_out      <= pc_out_d;
      pc_plus2    <= pc_plus2_d;
      valid       <= valid_d;
    end
  end

  // Next-state and next IF/ID contents; redirect outranks stall.
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    buf_instr_d   = buf_instr;
    buf_pc_d      = buf_pc;
    tgt_d         = tgt;
    instruction_d = instruction;
    pc_out_d      = pc_out;
    pc_plus2_d    = pc_plus2;
    valid_d       = valid;

    unique case (state)
      FETCH: begin
        if (redirect) begin
          valid_d       = 1'b0;
          instruction_d = '0;
          if (imem_resp) begin
            pc_d = redirect_tgt_c;
          end else begin
            tgt_d   = redirect_tgt_c;
            state_d = DISCARD;
          end
        end else if (imem_resp) begin
          pc_d = pc + PC_STEP;
          if (stall) begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc;
            state_d     = HOLD;
          end else begin
            instruction_d = imem_rdata;
            pc_out_d      = pc;
            pc_plus2_d    = pc + PC_STEP;
            valid_d       = 1'b1;
          end
        end else if (!stall) begin
          valid_d       = 1'b0;
          instruction_d = '0;
        end
      end

      HOLD: begin
        if (redirect) begin
          valid_d       = 1'b0;
          instruction_d = '0;
          pc_d          = redirect_tgt_c;
          state_d       = FETCH;
        end else if (!stall) begin
          instruction_d = buf_instr;
          pc_out_d      = buf_pc;
          pc_plus2_d    = buf_pc + PC_STEP;
          valid_d       = 1'b1;
          state_d       = FETCH;
        end
      end

      DISCARD: begin
        // IF/ID was flushed when the redirect arrived; keep it empty.
        valid_d       = 1'b0;
        instruction_d = '0;
        if (redirect) begin
          tgt_d = redirect_tgt_c;
        end
        if (imem_resp) begin
          pc_d    = redirect ? redirect_tgt_c : tgt;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined LC-3b core. It owns the program counter and issues reads to the instruction memory port using a read/resp handshake. It registers each fetched word, its PC and PC+2 into the IF/ID boundary consumed by the decode stage. It honours the decode stage's hazard stall and performs branch/jump redirects with flush.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- stall  in  1  hazard stall from decode; IF/ID outputs must hold
- redirect  in  1  taken branch/jump resolved downstream; flush and retarget
- redirect_pc  in  16  redirect target; bit 0 ignored (treated as 0)
- imem_read  out  1  instruction memory read request
- imem_address  out  16  instruction memory address
- imem_resp  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  16  fetched instruction word
- instruction  out  16  IF/ID instruction to decode; 16'h0000 (BR never = NOP) when invalid
- pc_out  out  16  PC of instruction
- pc_plus2  out  16  pc_out + 2
- valid  out  1  IF/ID holds a real instruction

## Operation
- Registers:
  - pc (16b, bit 0 always 0)
  - buf_instr (16b skid buffer)
  - buf_pc (16b)
  - tgt (16b pending redirect target)
  - IF/ID output registers
  - state in {FETCH, HOLD, DISCARD}
- Priority: reset > redirect > stall.
- Reset effects:
  - pc=RESET_PC, state=FETCH.
  - valid=0; instruction, pc_out and pc_plus2 = 16'h0000.
  - imem_read=0 while reset is high.
- imem_read = !reset && (state==FETCH || state==DISCARD).
- imem_address = pc. It stays stable while imem_read=1 until imem_resp.
- FETCH state:
  - resp, no stall: IF/ID <= {rdata, pc, pc+2}, valid<=1, pc<=pc+2.
  - resp with stall: buf_instr<=rdata, buf_pc<=pc, pc<=pc+2, state->HOLD. IF/ID holds.
  - no resp, no stall: IF/ID <= bubble (valid 0, instruction 16'h0000).
  - no resp with stall: IF/ID holds.
- HOLD state:
  - imem_read=0.
  - When stall drops: IF/ID <= {buf_instr, buf_pc, buf_pc+2}, valid<=1, state->FETCH.
- Redirect in FETCH:
  - Same cycle as resp: rdata is discarded, pc<=redirect_pc, state stays FETCH.
  - No resp: tgt<=redirect_pc, state->DISCARD. pc is unchanged so the outstanding request's address stays stable.
- Redirect in HOLD: buffer is dropped, pc<=redirect_pc, state->FETCH.
- Redirect in DISCARD: tgt is overwritten (latest redirect wins).
- DISCARD state:
  - imem_read=1 at the old pc.
  - On resp: rdata is dropped, pc<=tgt, state->FETCH.
- Any redirect forces an IF/ID bubble (valid<=0, instruction<=0) on that edge, even if stall=1.
- Arithmetic: 16-bit modulo; pc 16'hFFFE + 2 = 16'h0000. pc_plus2 wraps the same way.
- Reset mid-request: the outstanding read is abandoned. imem_read drops during reset, and fetch restarts at RESET_PC.

## Timing
- Zero-wait memory (resp in the same cycle as read): one instruction per clock.
- Fetch-to-IF/ID latency: instruction is visible on the edge that samples imem_resp.
- N-wait memory: N bubbles per instruction.
- Stall cost:
  - At most one word is buffered.
  - No read is issued while in HOLD.
  - The buffered word reaches IF/ID on the edge after stall deasserts.
- Redirect penalty:
  - 0 extra cycles if resp coincides.
  - Otherwise the remaining latency of the outstanding read, plus the new fetch.
- All outputs are registered except imem_read and imem_address, which are decoded from state and pc.

## Test plan
- Reset release, zero-wait memory returning pc-dependent words: IF/ID shows pc_out 0x0000, 0x0002, 0x0004 on consecutive cycles, with valid=1 from the first resp. Before that, all outputs are 0 and imem_read=0 during reset.
- Stall for 3 cycles while resp arrives at pc 0x0010:
  - IF/ID holds its old value.
  - imem_read is low in HOLD.
  - After stall drops, IF/ID shows the 0x0010 word with pc_plus2 0x0012; the next fetch address is 0x0012.
- 2-wait memory, redirect to 0x0040 in the first wait cycle, second redirect to 0x0080 one cycle later:
  - imem_address stays at the old pc until resp.
  - That data is dropped.
  - The next read is at 0x0080; valid=0 throughout.
- Redirect (0x0100) together with stall and resp in the same cycle: IF/ID flushed to valid=0/instruction 0, the response is discarded, and the next fetch is at 0x0100.
- PC wrap: redirect to 0xFFFE, then zero-wait fetch: pc_plus2=0x0000 and the next imem_address is 0x0000.
- Reset asserted in HOLD and in DISCARD: next cycle state is FETCH, pc=RESET_PC, valid=0, and no stale word reaches IF/ID.
